if_read: RTL and testbench
==========================

Name: if_read

Overview:
- Downstream neighbour of the ifmap store stage.
- Once the store stage has filled the ifmap SRAM with ROWS rows of ROW_WORDS 64-bit words, this block reads the SRAM back in column-interleaved order: row0 col c, row1 col c, row2 col c, then c+1.
- It presents the words on a valid/ready stream to the PE feeder.
- It absorbs the 1-cycle SRAM read latency and downstream backpressure with a 2-entry output buffer.

Parameters:
- TBITS, 64, stream and SRAM data width.
- ADDR_BITS, 11, SRAM address width.
- ROW_WORDS, 264, words per stored row (col0..col65 x 4 words).
- ROWS, 3, stored rows; total words NUM_WORDS = ROWS*ROW_WORDS (792 by default).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_if_read  in  1  start pulse from the instruction controller
- if_read_busy  out  1  high in RUN and DRAIN
- if_read_done  out  1  one-cycle pulse in DONE
- cen_ifsram  out  1  SRAM chip enable, active low
- wen_ifsram  out  1  SRAM write enable, active low; tied 1 (read only)
- addr_ifsram  out  ADDR_BITS  SRAM address
- dout_ifsram  in  TBITS  SRAM Q; valid the cycle after the read is sampled
- ifread_data_dout  out  TBITS  stream data (buffer head)
- ifread_valid_dout  out  1  stream valid
- ifread_ready_din  in  1  stream ready from consumer

Behaviour:
- Reset (async, active-high): state=IDLE; all counters, buffer and in-flight flag clear; cen_ifsram=1; addr_ifsram=0; ifread_valid_dout=0; ifread_data_dout=0; busy=0; done=0.
- FSM states and transitions:
  - IDLE -> RUN on start_if_read=1.
  - RUN -> DRAIN on the cycle the last read (issue count NUM_WORDS-1) is issued.
  - DRAIN -> DONE when the in-flight flag is clear, the buffer is empty and the last word has been accepted.
  - DONE -> IDLE unconditionally.
- start_if_read is ignored outside IDLE.
- Address generation: two counters, col in 0..ROW_WORDS-1 and row in 0..ROWS-1.
  - row increments on each issue; on row wrap, col increments.
  - addr = row*ROW_WORDS + col, computed in ADDR_BITS width; NUM_WORDS-1 must fit in ADDR_BITS (checked at elaboration).
- Issue rule (RUN only): cen_ifsram=0 when (buf_count + inflight - pop) < 2, where pop = ifread_valid_dout & ifread_ready_din.
  - cen_ifsram and addr_ifsram are combinational from the counters.
  - The counters advance on the issuing edge.
- In-flight flag is set on an issuing edge. On the following edge, dout_ifsram is written into the buffer and the flag clears, unless a new issue sets it again.
- Buffer: 2-entry FIFO. Push and pop in the same cycle are both honoured. Push when full must not occur; the issue rule guarantees this, and it is asserted in simulation.
- ifread_valid_dout = buffer not empty; ifread_data_dout = buffer head. Data must stay stable while valid=1 and ready=0.
- Latency: start sampled at edge E; first issue at edge E+1; first valid from edge E+2.
- Throughput: with ready held at 1, one word per cycle. The last word is accepted NUM_WORDS-1 cycles after the first.
- Done: if_read_done=1 for exactly the one cycle the FSM is in DONE. A new start may be accepted in the cycle after DONE.
- Reset mid-operation: everything returns to reset values immediately. Buffered and in-flight words are discarded; no done pulse.

Decomposition:
- Shared package (ifmap_pkg): IFMAP_SRAM_ADDBITS=11, IFMAP_SRAM_DATA_WIDTH=64, IF_ROW_WORDS=264, IF_ROWS=3, and FSM state encodings IDLE/RUN/DRAIN/DONE (2-bit).
  - The store stage and this block both import it.
- One sub-module: if_read_skid, a parameterised 2-entry FIFO (push/pop/count/head). It is reused later by the weight-read stage.

Test Plan:
- Default parameters, ready always 1, SRAM model preloaded with word=address -> stream is 0,264,528,1,265,529,...,263,527,791. First valid 2 cycles after the start edge; 792 consecutive valid beats; done pulse exactly once, 2 cycles after the last beat.
- Ready low for 5 cycles mid-stream, starting at beat 100 -> at most 2 reads are outstanding or buffered; cen_ifsram stays 1 while the buffer is full; the beat-100 data is held stable; no word is lost or duplicated; total 792.
- Ready toggling 1/0 every cycle -> ordered, complete 792 words; buffer never overflows (assertion silent).
- ROW_WORDS=4, ROWS=3 -> order 0,4,8,1,5,9,2,6,10,3,7,11; busy high from the start edge until DONE; done high for one cycle.
- start_if_read pulsed again at beat 50 -> ignored; exactly one run of 792 words and one done.
- reset asserted asynchronously at beat 300, then start reapplied -> outputs clear immediately; no done; the new run begins from address 0 and completes normally.

Source files
------------

// File: rtl/ifmap_pkg.sv
// ifmap_pkg: ifmap SRAM geometry and read-stage FSM encoding,
// shared by the ifmap store and read stages.
package ifmap_pkg;

  localparam int IFMAP_SRAM_ADDBITS    = 11;
  localparam int IFMAP_SRAM_DATA_WIDTH = 64;
  localparam int IF_ROW_WORDS          = 264;
  localparam int IF_ROWS               = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } if_state_e;

  function automatic int if_num_words(input int rows, input int row_words);
    return rows * row_words;
  endfunction

endpackage

// File: rtl/if_read_skid.sv
// if_read_skid: 2-entry FIFO; absorbs SRAM read latency and
// downstream backpressure. Push and pop may coincide.
module if_read_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;
  logic         full;

  assign empty_o = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      if (wr_ptr_q) mem1_d = push_data_i;
      else          mem0_d = push_data_i;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push_i} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream issue throttling must keep a push away from a full buffer.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(push_i && full)
  );

endmodule

// File: rtl/if_read.sv
// if_read: reads the ifmap SRAM back column-interleaved across
// rows and streams the words to the PE feeder over valid/ready.
module if_read
  import ifmap_pkg::*;
#(
  parameter int TBITS     = IFMAP_SRAM_DATA_WIDTH,
  parameter int ADDR_BITS = IFMAP_SRAM_ADDBITS,
  parameter int ROW_WORDS = IF_ROW_WORDS,
  parameter int ROWS      = IF_ROWS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_if_read,
  output logic                 if_read_busy,
  output logic                 if_read_done,
  output logic                 cen_ifsram,
  output logic                 wen_ifsram,
  output logic [ADDR_BITS-1:0] addr_ifsram,
  input  logic [TBITS-1:0]     dout_ifsram,
  output logic [TBITS-1:0]     ifread_data_dout,
  output logic                 ifread_valid_dout,
  input  logic                 ifread_ready_din
);

  localparam int NUM_WORDS = if_num_words(ROWS, ROW_WORDS);
  localparam int CB = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (NUM_WORDS - 1 >= (1 << ADDR_BITS)) begin : g_addr_chk
    $error("if_read: NUM_WORDS-1 does not fit in ADDR_BITS");
  end

  if_state_e      state_q, state_d;
  logic [RB-1:0]  row_q, row_d;
  logic [CB-1:0]  col_q, col_d;
  logic           inflight_q, inflight_d;

  logic [1:0]     buf_count;
  logic           buf_empty;
  logic           pop;
  logic [2:0]     occ;
  logic           issue;
  logic           row_wrap;
  logic           col_wrap;
  logic           last_issue;

  assign pop = ifread_valid_dout & ifread_ready_din;
  // Occupancy after this edge's pop; an issue keeps it at most 2.
  assign occ = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == RUN) && (occ < 3'd2);
  assign row_wrap   = (row_q == RB'(ROWS - 1));
  assign col_wrap   = (col_q == CB'(ROW_WORDS - 1));
  assign last_issue = issue & row_wrap & col_wrap;

  assign cen_ifsram  = ~issue;
  assign wen_ifsram  = 1'b1;
  assign addr_ifsram = ADDR_BITS'(row_q) * ADDR_BITS'(ROW_WORDS)
                     + ADDR_BITS'(col_q);

  assign inflight_d = issue;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (issue) begin
      row_d = row_wrap ? '0 : row_q + 1'b1;
      if (row_wrap) col_d = col_wrap ? '0 : col_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    if_read_busy = 1'b0;
    if_read_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_if_read) state_d = RUN;
      end
      RUN: begin
        if_read_busy = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if_read_busy = 1'b1;
        if (!inflight_q && buf_empty) state_d = DONE;
      end
      DONE: begin
        if_read_done = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
    end
  end

  if_read_skid #(
    .W (TBITS)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (dout_ifsram),
    .pop_i       (pop),
    .head_o      (ifread_data_dout),
    .count_o     (buf_count),
    .empty_o     (buf_empty)
  );

  assign ifread_valid_dout = ~buf_empty;

endmodule

// File: tb/tb_if_read.sv
// tb_if_read: directed scenarios for if_read with an SRAM model
// holding word = address; default and 4x3 geometries.
`timescale 1ns/1ps
module tb_if_read;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  bit   sel   = 1'b0;

  always #5 clk = ~clk;

  logic        a_busy, a_done, a_cen, a_wen, a_valid;
  logic [10:0] a_addr;
  logic [63:0] a_q = '0;
  logic [63:0] a_data;
  logic        b_busy, b_done, b_cen, b_wen, b_valid;
  logic [10:0] b_addr;
  logic [63:0] b_q = '0;
  logic [63:0] b_data;

  if_read u_a (
    .clk               (clk),
    .reset             (reset),
    .start_if_read     (start),
    .if_read_busy      (a_busy),
    .if_read_done      (a_done),
    .cen_ifsram        (a_cen),
    .wen_ifsram        (a_wen),
    .addr_ifsram       (a_addr),
    .dout_ifsram       (a_q),
    .ifread_data_dout  (a_data),
    .ifread_valid_dout (a_valid),
    .ifread_ready_din  (ready)
  );

  if_read #(.ROW_WORDS(4), .ROWS(3)) u_b (
    .clk               (clk),
    .reset             (reset),
    .start_if_read     (start),
    .if_read_busy      (b_busy),
    .if_read_done      (b_done),
    .cen_ifsram        (b_cen),
    .wen_ifsram        (b_wen),
    .addr_ifsram       (b_addr),
    .dout_ifsram       (b_q),
    .ifread_data_dout  (b_data),
    .ifread_valid_dout (b_valid),
    .ifread_ready_din  (ready)
  );

  always @(posedge clk) if (!a_cen) a_q <= 64'(a_addr);
  always @(posedge clk) if (!b_cen) b_q <= 64'(b_addr);

  logic        busy, done, cen, wen, valid;
  logic [10:0] addr;
  logic [63:0] data;

  always_comb begin
    busy  = sel ? b_busy  : a_busy;
    done  = sel ? b_done  : a_done;
    cen   = sel ? b_cen   : a_cen;
    wen   = sel ? b_wen   : a_wen;
    valid = sel ? b_valid : a_valid;
    addr  = sel ? b_addr  : a_addr;
    data  = sel ? b_data  : a_data;
  end

  int errors = 0;
  int checks = 0;

  logic [63:0] beats[$];
  int n_done, first_valid, last_beat_cyc, done_cyc;
  int max_out, cen_viol, hold_viol, busy_viol, rst_viol;
  logic [63:0] held_data;

  function automatic logic [63:0] exp_word(input int k);
    int r;
    int rw;
    r  = sel ? 3 : 3;
    rw = sel ? 4 : 264;
    return 64'((k % r) * rw + k / r);
  endfunction

  function automatic int order_bad();
    int bad = 0;
    foreach (beats[i]) if (beats[i] !== exp_word(i)) bad++;
    return bad;
  endfunction

  // mode 0: ready=1, 1: 5-cycle stall at beat 100, 2: toggle
  task automatic drive(input int mode, input int restart_beat,
                       input int rst_beat);
    int issued = 0;
    int accepted = 0;
    int stall = 0;
    int out;
    bit prev_stall = 0;
    bit restarted = 0;
    logic [63:0] prev_data = '0;
    beats.delete();
    n_done = 0; first_valid = -1; last_beat_cyc = -1; done_cyc = -1;
    max_out = 0; cen_viol = 0; hold_viol = 0; busy_viol = 0;
    rst_viol = 0; held_data = '0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (!restarted && restart_beat >= 0 &&
          beats.size() == restart_beat) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (rst_beat >= 0 && beats.size() == rst_beat) begin
        reset = 1'b1;
        #1;
        if (valid !== 1'b0 || data !== 64'd0 || cen !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0 || addr !== 11'd0)
          rst_viol++;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      case (mode)
        1: begin
          if (beats.size() >= 100 && stall < 5) begin
            ready = 1'b0;
            stall++;
          end else ready = 1'b1;
        end
        2: ready = ((cyc % 2) == 0);
        default: ready = 1'b1;
      endcase
      #1;
      if (mode == 1 && !ready && stall == 1) held_data = data;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (n_done == 0 && !busy) busy_viol++;
      if (done && busy) busy_viol++;
      if (prev_stall && (!valid || data !== prev_data)) hold_viol++;
      if (valid && first_valid < 0) first_valid = cyc;
      out = issued - accepted;
      if (!cen) begin
        if (out == 2 && !(valid && ready)) cen_viol++;
        issued++;
      end
      if (valid && ready) begin
        beats.push_back(data);
        accepted++;
        last_beat_cyc = cyc;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      prev_stall = valid && !ready;
      prev_data  = data;
      if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    int bad = 0;
    sel = 0;
    #2 reset = 1'b1;
    #3;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (data !== 64'd0) begin errors++; $display("FAIL reset_data got %0h want 0", data); end
    checks++; if (cen !== 1'b1) begin errors++; $display("FAIL reset_cen got %b want 1", cen); end
    checks++; if (wen !== 1'b1) begin errors++; $display("FAIL reset_wen got %b want 1", wen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (addr !== 11'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (valid || busy || done || !cen) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_idle got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_stream();
    int bad;
    logic [63:0] w1, wl;
    sel = 0;
    drive(0, -1, -1);
    bad = order_bad();
    w1 = (beats.size() > 1) ? beats[1] : '1;
    wl = (beats.size() > 791) ? beats[791] : '1;
    checks++; if (beats.size() !== 792) begin errors++; $display("FAIL stream_count got %0d want 792", beats.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stream_order got %0d bad want 0", bad); end
    checks++; if (w1 !== 64'd264) begin errors++; $display("FAIL stream_beat1 got %0d want 264", w1); end
    checks++; if (wl !== 64'd791) begin errors++; $display("FAIL stream_last got %0d want 791", wl); end
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL stream_latency got %0d want 2", first_valid); end
    checks++; if (last_beat_cyc - first_valid !== 791) begin errors++; $display("FAIL stream_span got %0d want 791", last_beat_cyc - first_valid); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL stream_done_count got %0d want 1", n_done); end
    checks++; if (done_cyc - last_beat_cyc !== 2) begin errors++; $display("FAIL stream_done_time got %0d want 2", done_cyc - last_beat_cyc); end
    checks++; if (busy_viol !== 0) begin errors++; $display("FAIL stream_busy got %0d bad want 0", busy_viol); end
  endtask

  task automatic test_stall();
    int bad;
    sel = 0;
    drive(1, -1, -1);
    bad = order_bad();
    checks++; if (beats.size() !== 792) begin errors++; $display("FAIL stall_count got %0d want 792", beats.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_order got %0d bad want 0", bad); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL stall_outstanding got %0d want <=2", max_out); end
    checks++; if (cen_viol !== 0) begin errors++; $display("FAIL stall_cen_full got %0d want 0", cen_viol); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d want 0", hold_viol); end
    checks++; if (held_data !== 64'd297) begin errors++; $display("FAIL stall_beat100 got %0d want 297", held_data); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL stall_done got %0d want 1", n_done); end
  endtask

  task automatic test_toggle();
    int bad;
    sel = 0;
    drive(2, -1, -1);
    bad = order_bad();
    checks++; if (beats.size() !== 792) begin errors++; $display("FAIL toggle_count got %0d want 792", beats.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_order got %0d bad want 0", bad); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL toggle_hold got %0d want 0", hold_viol); end
    checks++; if (cen_viol !== 0) begin errors++; $display("FAIL toggle_cen_full got %0d want 0", cen_viol); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL toggle_done got %0d want 1", n_done); end
  endtask

  task automatic test_restart();
    int bad;
    sel = 0;
    drive(0, 50, -1);
    bad = order_bad();
    checks++; if (beats.size() !== 792) begin errors++; $display("FAIL restart_count got %0d want 792", beats.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL restart_order got %0d bad want 0", bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL restart_done got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic [63:0] w0;
    sel = 0;
    drive(0, -1, 300);
    checks++; if (beats.size() !== 300) begin errors++; $display("FAIL rstmid_beats got %0d want 300", beats.size()); end
    checks++; if (rst_viol !== 0) begin errors++; $display("FAIL rstmid_clear got %0d bad want 0", rst_viol); end
    repeat (5) begin
      @(negedge clk);
      if (done || valid || busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad want 0", bad); end
    drive(0, -1, -1);
    bad = order_bad();
    w0 = (beats.size() > 0) ? beats[0] : '1;
    checks++; if (w0 !== 64'd0) begin errors++; $display("FAIL rstmid_first got %0d want 0", w0); end
    checks++; if (beats.size() !== 792) begin errors++; $display("FAIL rstmid_count got %0d want 792", beats.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_order got %0d bad want 0", bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL rstmid_done got %0d want 1", n_done); end
  endtask

  task automatic test_small();
    int exp_s[12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    int bad = 0;
    sel = 1;
    drive(0, -1, -1);
    foreach (beats[i]) if (i < 12 && beats[i] !== 64'(exp_s[i])) bad++;
    checks++; if (beats.size() !== 12) begin errors++; $display("FAIL small_count got %0d want 12", beats.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL small_order got %0d bad want 0", bad); end
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL small_latency got %0d want 2", first_valid); end
    checks++; if (busy_viol !== 0) begin errors++; $display("FAIL small_busy got %0d bad want 0", busy_viol); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL small_done got %0d want 1", n_done); end
    checks++; if (done_cyc - last_beat_cyc !== 2) begin errors++; $display("FAIL small_done_time got %0d want 2", done_cyc - last_beat_cyc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_toggle();
    test_restart();
    test_reset_mid();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
